// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//   Recovers hex digits from a scanned, active-low 7-segment bus. The bus is
//   one shared segment pattern plus a one-hot digit select. Each digit has
//   its own stability filter: a pattern is committed only after STABLE
//   consecutive identical samples, and only if it differs from the pattern
//   already committed. Every commit is offered to a single-entry event
//   channel with a valid/ready handshake.
//
//   Optional feature macro: SEG7_DP_EN. When it is defined, a decimal-point
//   input is added. The filter then compares {dp, leds}. The bus also gains
//   dp_out, and upd_flags becomes {dp, pat_err, blank}.
//
// Ports
//   clk          clock, all logic on posedge
//   reset        synchronous, active-high
//   sample_en    leds/dig_sel are valid this cycle
//   dig_sel      one-hot digit select
//   leds         active-low segment pattern (bit 6 = middle ... bit 0 = top)
//   dp           (SEG7_DP_EN only) active-low decimal point
//   hex_out      committed hex per digit, digit d at [4d+3:4d]
//   digit_valid  committed pattern is a hex code
//   blank        committed pattern is all segments off
//   pat_err      committed pattern is neither hex nor blank
//   dp_out       (SEG7_DP_EN only) decimal point of the committed sample
//   sel_err      one-cycle pulse for a sample with a non-one-hot select
//   upd_valid / upd_ready / upd_digit / upd_hex / upd_flags
//                single-entry update-event channel
//   overrun      sticky: a commit found the channel full and was dropped
module seg7_scan_decoder #(
  parameter int NDIG   = 6,
  parameter int STABLE = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_en,
  input  logic [NDIG-1:0]   dig_sel,
  input  logic [6:0]        leds,
`ifdef SEG7_DP_EN
  input  logic              dp,
  output logic [NDIG-1:0]   dp_out,
  output logic [2:0]        upd_flags,
`else
  output logic [1:0]        upd_flags,
`endif
  output logic [4*NDIG-1:0] hex_out,
  output logic [NDIG-1:0]   digit_valid,
  output logic [NDIG-1:0]   blank,
  output logic [NDIG-1:0]   pat_err,
  output logic              sel_err,
  output logic              upd_valid,
  input  logic              upd_ready,
  output logic [2:0]        upd_digit,
  output logic [3:0]        upd_hex,
  output logic              overrun
);

`ifdef SEG7_DP_EN
  localparam int PW = 8;
`else
  localparam int PW = 7;
`endif
  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE);

  logic [PW-1:0] cand      [NDIG];
  logic [CW-1:0] cnt       [NDIG];
  logic [PW-1:0] committed [NDIG];

  logic [PW-1:0] samp;
  logic          sel_one;
  logic          sel_ok;
  logic [2:0]    idx;
  logic [PW-1:0] cur_cand;
  logic [CW-1:0] cur_cnt;
  logic [PW-1:0] cur_comm;
  logic [CW-1:0] cnt_nxt;
  logic          commit;
  logic [4:0]    dec;
  logic          is_blank;
  logic          is_err;

  // Returns {valid, hex}; hex is 0 when the pattern is not a hex code.
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    case (p)
      7'h40:   return 5'h10;
      7'h79:   return 5'h11;
      7'h24:   return 5'h12;
      7'h30:   return 5'h13;
      7'h19:   return 5'h14;
      7'h12:   return 5'h15;
      7'h02:   return 5'h16;
      7'h78:   return 5'h17;
      7'h00:   return 5'h18;
      7'h10:   return 5'h19;
      7'h08:   return 5'h1A;
      7'h03:   return 5'h1B;
      7'h46:   return 5'h1C;
      7'h21:   return 5'h1D;
      7'h06:   return 5'h1E;
      7'h0E:   return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

`ifdef SEG7_DP_EN
  assign samp = {dp, leds};
`else
  assign samp = leds;
`endif

  assign sel_one  = ($countones(dig_sel) == 1);
  assign sel_ok   = sample_en && sel_one;
  assign dec      = seg_decode(samp[6:0]);
  assign is_blank = (samp[6:0] == 7'h7F);
  assign is_err   = !dec[4] && !is_blank;

  // Only the selected digit's filter state matters this cycle, so pull it
  // out once and compute its next count / commit decision here.
  always_comb begin
    idx      = '0;
    cur_cand = '1;
    cur_cnt  = '0;
    cur_comm = '1;
    for (int d = 0; d < NDIG; d++) begin
      if (dig_sel[d]) begin
        idx      = 3'(d);
        cur_cand = cand[d];
        cur_cnt  = cnt[d];
        cur_comm = committed[d];
      end
    end
    if (samp == cur_cand)
      cnt_nxt = (cur_cnt == STABLE_C) ? cur_cnt : cur_cnt + CW'(1);
    else
      cnt_nxt = CW'(1);
    commit = sel_ok && (cnt_nxt == STABLE_C) && (samp != cur_comm);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int d = 0; d < NDIG; d++) begin
        cand[d]      <= '1;
        cnt[d]       <= '0;
        committed[d] <= '1;
      end
      hex_out     <= '0;
      digit_valid <= '0;
      blank       <= '1;
      pat_err     <= '0;
      sel_err     <= 1'b0;
      upd_valid   <= 1'b0;
      upd_digit   <= '0;
      upd_hex     <= '0;
      upd_flags   <= '0;
      overrun     <= 1'b0;
`ifdef SEG7_DP_EN
      dp_out      <= '0;
`endif
    end else begin
      sel_err <= sample_en && !sel_one;

      for (int d = 0; d < NDIG; d++) begin
        if (sel_ok && dig_sel[d]) begin
          // On a match cand is rewritten with the same value.
          cand[d] <= samp;
          cnt[d]  <= cnt_nxt;
          if (commit) begin
            committed[d]       <= samp;
            hex_out[4*d +: 4]  <= dec[3:0];
            digit_valid[d]     <= dec[4];
            blank[d]           <= is_blank;
            pat_err[d]         <= is_err;
`ifdef SEG7_DP_EN
            dp_out[d]          <= ~samp[7];
`endif
          end
        end
      end

      if (upd_valid && upd_ready)
        upd_valid <= 1'b0;

      // A slot being drained this cycle counts as free.
      if (commit) begin
        if (!upd_valid || upd_ready) begin
          upd_valid <= 1'b1;
          upd_digit <= idx;
          upd_hex   <= dec[3:0];
`ifdef SEG7_DP_EN
          upd_flags <= {~samp[7], is_err, is_blank};
`else
          upd_flags <= {is_err, is_blank};
`endif
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder
//   Self-checking bench for seg7_scan_decoder (default build, NDIG=6,
//   STABLE=3). Inputs change 1 time unit after posedge; checks happen at
//   the same point. Expected update events are queued when the stimulus
//   that should cause them is driven. They are popped and compared when the
//   monitor sees a handshake.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_en;
  logic [5:0]  dig_sel;
  logic [6:0]  leds;
  logic [23:0] hex_out;
  logic [5:0]  digit_valid;
  logic [5:0]  blank;
  logic [5:0]  pat_err;
  logic        sel_err;
  logic        upd_valid;
  logic        upd_ready;
  logic [2:0]  upd_digit;
  logic [3:0]  upd_hex;
  logic [1:0]  upd_flags;
  logic        overrun;

  seg7_scan_decoder #(.NDIG(6), .STABLE(3)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .dig_sel(dig_sel),
    .leds(leds), .upd_flags(upd_flags), .hex_out(hex_out),
    .digit_valid(digit_valid), .blank(blank), .pat_err(pat_err),
    .sel_err(sel_err), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_digit(upd_digit), .upd_hex(upd_hex), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         dig;
    logic [6:0] pat;
    int         n;
    logic [3:0] hex;
    logic       v;
    logic       b;
    logic       e;
    logic       ev;
  } vec_t;

  typedef struct {
    logic [2:0] d;
    logic [3:0] h;
    logic [1:0] f;
  } ev_t;

  vec_t vecs[13];
  ev_t  sbq[$];
  logic [6:0] codes[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [5:0] sel, input logic [6:0] p);
    sample_en = en;
    dig_sel   = sel;
    leds      = p;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 6'b0, 7'h7F);
  endtask

  task automatic samp(input int d, input logic [6:0] p, input int n);
    repeat (n) drive(1'b1, 6'(1 << d), p);
  endtask

  task automatic push(input int d, input logic [3:0] h, input logic [1:0] f);
    ev_t e;
    e.d = 3'(d);
    e.h = h;
    e.f = f;
    sbq.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_blank"}, 32'(blank), 32'h3F);
    chk({tag, "_digit_valid"}, 32'(digit_valid), 32'h0);
    chk({tag, "_hex_out"}, 32'(hex_out), 32'h0);
    chk({tag, "_pat_err"}, 32'(pat_err), 32'h0);
    chk({tag, "_upd_valid"}, 32'(upd_valid), 32'h0);
    chk({tag, "_overrun"}, 32'(overrun), 32'h0);
  endtask

  // Handshake monitor: the event is consumed at the next posedge.
  always @(negedge clk) begin
    ev_t e;
    if (!reset && upd_valid && upd_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event actual digit=%0d hex=%0h expected none",
                 upd_digit, upd_hex);
      end else begin
        e = sbq.pop_front();
        chk("evt_digit", 32'(upd_digit), 32'(e.d));
        chk("evt_hex", 32'(upd_hex), 32'(e.h));
        chk("evt_flags", 32'(upd_flags), 32'(e.f));
      end
    end
  end

  initial begin
    int d;
    int wait_cnt;

    reset     = 1'b1;
    sample_en = 1'b0;
    dig_sel   = '0;
    leds      = 7'h7F;
    upd_ready = 1'b1;

    codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    //           dig pat    n  hex   v     b     e     ev
    vecs[0]  = '{2, 7'h30, 3, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{0, 7'h12, 2, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{0, 7'h02, 1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{0, 7'h02, 2, 4'h6, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{5, 7'h7E, 3, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{3, 7'h0E, 3, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{3, 7'h0E, 3, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1, 7'h7F, 3, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{4, 7'h08, 2, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{4, 7'h08, 1, 4'hA, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{4, 7'h7F, 3, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{0, 7'h40, 3, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1, 7'h79, 3, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1};

    @(posedge clk);
    #1;
    idle(2);
    reset = 1'b0;
    check_reset_state("rst");
    chk("rst_sel_err", 32'(sel_err), 32'h0);

    // Table-driven vectors, consumer always ready.
    for (int i = 0; i < 13; i++) begin
      d = vecs[i].dig;
      if (vecs[i].ev) push(d, vecs[i].hex, {vecs[i].e, vecs[i].b});
      samp(d, vecs[i].pat, vecs[i].n);
      chk($sformatf("vec%0d_hex", i), 32'(hex_out[4*d +: 4]), 32'(vecs[i].hex));
      chk($sformatf("vec%0d_valid", i), 32'(digit_valid[d]), 32'(vecs[i].v));
      chk($sformatf("vec%0d_blank", i), 32'(blank[d]), 32'(vecs[i].b));
      chk($sformatf("vec%0d_pat_err", i), 32'(pat_err[d]), 32'(vecs[i].e));
      chk($sformatf("vec%0d_upd_valid", i), 32'(upd_valid), 32'(vecs[i].ev));
    end

    // Every hex code on digit 1 (each differs from the previous one).
    for (int c = 0; c < 16; c++) begin
      push(1, 4'(c), 2'b00);
      samp(1, codes[c], 3);
      chk($sformatf("code%0d_hex", c), 32'(hex_out[7:4]), 32'(c));
      chk($sformatf("code%0d_valid", c), 32'(digit_valid[1]), 32'h1);
    end
    idle(3);
    chk("drain1_queue", 32'(sbq.size()), 32'h0);

    // Back-pressure, load on the handshake cycle, then overrun.
    upd_ready = 1'b0;
    push(1, 4'h2, 2'b00);
    samp(1, 7'h24, 3);
    idle(2);
    chk("hold_upd_valid", 32'(upd_valid), 32'h1);
    chk("hold_upd_digit", 32'(upd_digit), 32'h1);
    chk("hold_upd_hex", 32'(upd_hex), 32'h2);
    samp(2, 7'h12, 2);
    upd_ready = 1'b1;
    push(2, 4'h5, 2'b00);
    samp(2, 7'h12, 1);
    upd_ready = 1'b0;
    chk("reload_upd_valid", 32'(upd_valid), 32'h1);
    chk("reload_upd_digit", 32'(upd_digit), 32'h2);
    chk("reload_upd_hex", 32'(upd_hex), 32'h5);
    chk("reload_overrun", 32'(overrun), 32'h0);
    samp(4, 7'h19, 3);
    chk("ovr_overrun", 32'(overrun), 32'h1);
    chk("ovr_upd_digit", 32'(upd_digit), 32'h2);
    chk("ovr_upd_hex", 32'(upd_hex), 32'h5);
    chk("ovr_hex4", 32'(hex_out[19:16]), 32'h4);
    chk("ovr_valid4", 32'(digit_valid[4]), 32'h1);
    upd_ready = 1'b1;
    idle(2);
    chk("drain2_upd_valid", 32'(upd_valid), 32'h0);
    chk("drain2_queue", 32'(sbq.size()), 32'h0);
    chk("drain2_overrun_sticky", 32'(overrun), 32'h1);

    // Illegal selects and sample_en=0 must not advance the digit 0 filter.
    samp(0, 7'h24, 2);
    drive(1'b1, 6'b000011, 7'h24);
    chk("sel2_sel_err", 32'(sel_err), 32'h1);
    chk("sel2_hex0", 32'(hex_out[3:0]), 32'h0);
    chk("sel2_upd_valid", 32'(upd_valid), 32'h0);
    idle(1);
    chk("sel2_pulse_end", 32'(sel_err), 32'h0);
    drive(1'b1, 6'b000000, 7'h24);
    chk("sel0_sel_err", 32'(sel_err), 32'h1);
    drive(1'b0, 6'b000001, 7'h24);
    chk("en0_sel_err", 32'(sel_err), 32'h0);
    chk("en0_hex0", 32'(hex_out[3:0]), 32'h0);
    chk("en0_upd_valid", 32'(upd_valid), 32'h0);
    push(0, 4'h2, 2'b00);
    samp(0, 7'h24, 1);
    chk("sel_commit_hex0", 32'(hex_out[3:0]), 32'h2);
    idle(2);
    chk("drain3_queue", 32'(sbq.size()), 32'h0);

    // Reset between the 2nd and 3rd stable sample.
    samp(3, 7'h19, 2);
    sbq.delete();
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check_reset_state("mid");
    samp(3, 7'h19, 1);
    chk("mid_no_commit_blank3", 32'(blank[3]), 32'h1);
    chk("mid_no_commit_upd", 32'(upd_valid), 32'h0);
    push(3, 4'h4, 2'b00);
    samp(3, 7'h19, 2);
    chk("mid_commit_hex3", 32'(hex_out[15:12]), 32'h4);

    wait_cnt = 0;
    while (sbq.size() != 0 && wait_cnt < 20) begin
      idle(1);
      wait_cnt++;
    end
    chk("final_queue", 32'(sbq.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
